// File: rtl/lb_pkg.sv
// lb_pkg: shared defaults, pixel type and window arithmetic for line_buffer_mc.
//   No ports; imported by line_buffer_mc and its testbench.
package lb_pkg;
    localparam int LB_I_F_BW = 8;
    localparam int LB_IX = 28;
    localparam int LB_IY = 28;
    localparam int LB_KX = 5;
    localparam int LB_KY = 5;
    localparam int LB_CH = 1;
    localparam int LB_STRIDE = 1;

    typedef logic [LB_I_F_BW-1:0] pix_t;

    // windows along one axis
    function automatic int win_count(input int ix, input int kx, input int stride);
        return (ix - kx) / stride + 1;
    endfunction

    function automatic int win_bits(input int ch, input int ky, input int kx, input int bw);
        return ch * ky * kx * bw;
    endfunction

    // lsb of element (c,wy,wx) inside the flattened window
    function automatic int win_lsb(input int c, input int wy, input int wx,
                                   input int ky, input int kx, input int bw);
        return ((c * ky + wy) * kx + wx) * bw;
    endfunction

    localparam int LB_WIN_W = win_bits(LB_CH, LB_KY, LB_KX, LB_I_F_BW);
endpackage

// File: rtl/lb_row_ram.sv
// lb_row_ram: simple dual-port line memory, one write port, registered 1-cycle read.
//   clk; we_i/waddr_i/wdata_i write port; raddr_i -> rdata_o one cycle later.
module lb_row_ram #(
    parameter int DEPTH = 28,
    parameter int W = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/line_buffer_mc.sv
// line_buffer_mc: multi-channel strided sliding-window generator with valid/ready backpressure.
//   clk, reset (async, active-high), i_clear (sync frame abort, drops a concurrent beat)
//   i_in_valid/o_in_ready/i_in_pixel : raster-order input, CH channels per beat
//   o_window_valid/i_window_ready/o_window : KX x KY x CH window per qualifying position
//   o_if_x/o_if_y : top-left input coordinate of the window
//   o_frame_done : one-cycle pulse after the last pixel of a frame is accepted
module line_buffer_mc
    import lb_pkg::*;
#(
    parameter int I_F_BW = LB_I_F_BW,
    parameter int IX = LB_IX,
    parameter int IY = LB_IY,
    parameter int KX = LB_KX,
    parameter int KY = LB_KY,
    parameter int CH = LB_CH,
    parameter int STRIDE = LB_STRIDE
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_clear,
    input  logic                                  i_in_valid,
    output logic                                  o_in_ready,
    input  logic [CH*I_F_BW-1:0]                  i_in_pixel,
    output logic                                  o_window_valid,
    input  logic                                  i_window_ready,
    output logic [win_bits(CH, KY, KX, I_F_BW)-1:0] o_window,
    output logic [$clog2(IX)-1:0]                 o_if_x,
    output logic [$clog2(IY)-1:0]                 o_if_y,
    output logic                                  o_frame_done
);
    localparam int XW = $clog2(IX);
    localparam int YW = $clog2(IY);
    localparam int PW = $clog2(STRIDE + 1);
    localparam int LW = CH * I_F_BW;

    logic [XW-1:0] x_q, x_d, x_n, if_x_q, if_x_d;
    logic [YW-1:0] y_q, y_d, y_n, if_y_q, if_y_d;
    logic [PW-1:0] px_q, px_d, px_n, py_q, py_d, py_n;
    logic x_last, y_last, qual, take;
    logic valid_q, valid_d, done_q, done_d;
    logic [LW-1:0] line_rd [KY-1];
    logic [I_F_BW-1:0] col [CH][KY];
    logic [I_F_BW-1:0] win_q [CH][KY][KX];
    logic [I_F_BW-1:0] win_d [CH][KY][KX];

    assign o_in_ready = !valid_q || i_window_ready;
    assign take = i_in_valid && o_in_ready && !i_clear;
    assign o_window_valid = valid_q;
    assign o_if_x = if_x_q;
    assign o_if_y = if_y_q;
    assign o_frame_done = done_q;

    // Phases track (x-(KX-1)) mod STRIDE and (y-(KY-1)) mod STRIDE without dividers.
    always_comb begin
        x_last = x_q == XW'(IX - 1);
        y_last = y_q == YW'(IY - 1);
        x_n = x_last ? '0 : x_q + XW'(1);
        y_n = !x_last ? y_q : y_last ? '0 : y_q + YW'(1);
        px_n = (x_n == XW'(KX - 1) || px_q == PW'(STRIDE - 1)) ? '0 : px_q + PW'(1);
        py_n = !x_last ? py_q : (y_n == YW'(KY - 1) || py_q == PW'(STRIDE - 1)) ? '0 : py_q + PW'(1);
        qual = x_q >= XW'(KX - 1) && y_q >= YW'(KY - 1) && px_q == '0 && py_q == '0;
        x_d = i_clear ? '0 : take ? x_n : x_q;
        y_d = i_clear ? '0 : take ? y_n : y_q;
        px_d = i_clear ? '0 : take ? px_n : px_q;
        py_d = i_clear ? '0 : take ? py_n : py_q;
        valid_d = i_clear ? 1'b0 : take ? qual : valid_q && !i_window_ready;
        if_x_d = i_clear ? '0 : (take && qual) ? x_q - XW'(KX - 1) : if_x_q;
        if_y_d = i_clear ? '0 : (take && qual) ? y_q - YW'(KY - 1) : if_y_q;
        done_d = take && x_last && y_last;
    end

    // Incoming column: current pixel at the bottom, line k (k rows back) above it.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            col[c][KY-1] = i_in_pixel[c*I_F_BW +: I_F_BW];
            for (int l = 0; l < KY - 1; l++) col[c][KY-2-l] = line_rd[l][c*I_F_BW +: I_F_BW];
        end
    end

    always_comb begin
        win_d = win_q;
        for (int c = 0; c < CH; c++) begin
            for (int wy = 0; wy < KY; wy++) begin
                for (int wx = 0; wx < KX - 1; wx++)
                    win_d[c][wy][wx] = i_clear ? '0 : take ? win_q[c][wy][wx+1] : win_q[c][wy][wx];
                win_d[c][wy][KX-1] = i_clear ? '0 : take ? col[c][wy] : win_q[c][wy][KX-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
            px_q <= '0;
            py_q <= '0;
            valid_q <= 1'b0;
            if_x_q <= '0;
            if_y_q <= '0;
            done_q <= 1'b0;
            win_q <= '{default: '0};
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            px_q <= px_d;
            py_q <= py_d;
            valid_q <= valid_d;
            if_x_q <= if_x_d;
            if_y_q <= if_y_d;
            done_q <= done_d;
            win_q <= win_d;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_c
        for (genvar y = 0; y < KY; y++) begin : g_y
            for (genvar x = 0; x < KX; x++) begin : g_x
                assign o_window[win_lsb(c, y, x, KY, KX, I_F_BW) +: I_F_BW] = win_q[c][y][x];
            end
        end
    end

    // Reads are issued for the next beat's column (x_d) so data is ready when that
    // beat arrives; the write goes to x_q, so back-to-back beats never collide.
    for (genvar k = 0; k < KY - 1; k++) begin : g_line
        logic [LW-1:0] wdata;
        if (k == 0) begin : g_head
            assign wdata = i_in_pixel;
        end else begin : g_tail
            assign wdata = line_rd[k-1];
        end
        lb_row_ram #(.DEPTH(IX), .W(LW)) u_ram (
            .clk(clk),
            .we_i(take),
            .waddr_i(x_q),
            .wdata_i(wdata),
            .raddr_i(x_d),
            .rdata_o(line_rd[k])
        );
    end
endmodule

// File: tb/tb_line_buffer_mc.sv
// tb_line_buffer_mc: scoreboard bench; CH=3 stride-1 and CH=1 stride-2 instances fed one stream.
module tb_line_buffer_mc;
    import lb_pkg::*;
    localparam int IX = 28, IY = 28, K = 5;
    localparam int W1 = 3 * K * K * 8;
    localparam int W2 = LB_WIN_W;
    typedef struct {
        logic [W1-1:0] w;
        int x;
        int y;
    } exp_t;

    logic clk = 0, rst = 1, clr = 0, vin = 0, wrdy = 1;
    logic [23:0] pix = '0;
    logic rdy1, vld1, fd1, rdy2, vld2, fd2;
    logic [W1-1:0] win1, snap;
    logic [W2-1:0] win2;
    logic [4:0] ix1, iy1, ix2, iy2, sx, sy;
    exp_t q1[$], q2[$];
    exp_t e1, e2;
    int checks = 0, errors = 0, n1 = 0, n2 = 0, nfd = 0, nacc = 0;
    logic bp_arm = 0, rnd = 0, gaps = 0, chk_second = 0, f2chk = 0;

    always #5 clk = ~clk;

    line_buffer_mc #(.CH(3), .STRIDE(1)) dut (
        .clk(clk), .reset(rst), .i_clear(clr), .i_in_valid(vin), .o_in_ready(rdy1),
        .i_in_pixel(pix), .o_window_valid(vld1), .i_window_ready(wrdy), .o_window(win1),
        .o_if_x(ix1), .o_if_y(iy1), .o_frame_done(fd1));

    line_buffer_mc #(.CH(1), .STRIDE(2)) dut2 (
        .clk(clk), .reset(rst), .i_clear(clr), .i_in_valid(vin && rdy1), .o_in_ready(rdy2),
        .i_in_pixel(pix[7:0]), .o_window_valid(vld2), .i_window_ready(1'b1), .o_window(win2),
        .o_if_x(ix2), .o_if_y(iy2), .o_frame_done(fd2));

    function automatic pix_t pv(input int c, input int x, input int y, input int off);
        return pix_t'(y * IX + x + 1 + off + 64 * c);
    endfunction

    function automatic exp_t mk(input int x, input int y, input int off, input int nch);
        exp_t e;
        e.w = '0;
        e.x = x - (K - 1);
        e.y = y - (K - 1);
        for (int c = 0; c < nch; c++)
            for (int wy = 0; wy < K; wy++)
                for (int wx = 0; wx < K; wx++)
                    e.w[((c * K + wy) * K + wx) * 8 +: 8] = pv(c, e.x + wx, e.y + wy, off);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [W1-1:0] act, input logic [W1-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input int x, input int y, input int off);
        int t = 0;
        pix = {pv(2, x, y, off), pv(1, x, y, off), pv(0, x, y, off)};
        vin = 1;
        @(negedge clk);
        while (!rdy1) begin
            t++;
            if (t > 300) begin
                errors++;
                $display("FAIL beat_timeout: in_ready stuck low at x=%0d y=%0d", x, y);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
            @(negedge clk);
        end
        nacc++;
        if (x >= K - 1 && y >= K - 1) q1.push_back(mk(x, y, off, 3));
        if (x >= K - 1 && y >= K - 1 && (x - K + 1) % 2 == 0 && (y - K + 1) % 2 == 0)
            q2.push_back(mk(x, y, off, 1));
        @(posedge clk);
        #1;
        vin = 0;
    endtask

    task automatic frame(input int off, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (gaps) idle($urandom_range(0, 1));
            beat(i % IX, i / IX, off);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk($sformatf("%s_window", tag), win1, '0);
        chk($sformatf("%s_window2", tag), W1'(win2), '0);
        chki($sformatf("%s_valid", tag), int'(vld1), 0);
        chki($sformatf("%s_valid2", tag), int'(vld2), 0);
        chki($sformatf("%s_if_x", tag), int'(ix1), 0);
        chki($sformatf("%s_if_y", tag), int'(iy1), 0);
        chki($sformatf("%s_done", tag), int'(fd1), 0);
        chki($sformatf("%s_in_ready", tag), int'(rdy1), 1);
        chki($sformatf("%s_in_ready2", tag), int'(rdy2), 1);
    endtask

    task automatic counts(input string tag, input int w1, input int w2, input int fd);
        chki($sformatf("%s_windows", tag), n1, w1);
        chki($sformatf("%s_windows_s2", tag), n2, w2);
        chki($sformatf("%s_frame_done", tag), nfd, fd);
        chki($sformatf("%s_pending", tag), q1.size() + q2.size(), 0);
    endtask

    // Fresh frame after reset/clear: nothing before the 117th pixel, window at (0,0) right after it.
    task automatic fresh(input int off, input string tag);
        n1 = 0;
        n2 = 0;
        nfd = 0;
        for (int i = 0; i < 116; i++) beat(i % IX, i / IX, off);
        chki($sformatf("%s_valid_pre117", tag), int'(vld1), 0);
        beat(4, 4, off);
        chki($sformatf("%s_valid_at117", tag), int'(vld1), 1);
        chki($sformatf("%s_if_x_at117", tag), int'(ix1), 0);
        chki($sformatf("%s_if_y_at117", tag), int'(iy1), 0);
        for (int i = 117; i < IX * IY; i++) beat(i % IX, i / IX, off);
        idle(5);
        counts(tag, 576, 144, 1);
    endtask

    always @(negedge clk) begin
        if (vld1 && wrdy) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL win_unexpected: got window at x=%0d y=%0d expected none", ix1, iy1);
            end else begin
                e1 = q1.pop_front();
                chk("window", win1, e1.w);
                chki("if_x", int'(ix1), e1.x);
                chki("if_y", int'(iy1), e1.y);
                if (f2chk && n1 == 576)
                    for (int wx = 0; wx < K; wx++)
                        chki("frame2_first_row0", int'(win1[wx*8 +: 8]), 101 + wx);
            end
            n1++;
        end
        if (vld2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL win2_unexpected: got window at x=%0d y=%0d expected none", ix2, iy2);
            end else begin
                e2 = q2.pop_front();
                chk("window_s2", W1'(win2), e2.w);
                chki("if_x_s2", int'(ix2), e2.x);
                chki("if_y_s2", int'(iy2), e2.y);
                if (chk_second && n2 == 1)
                    for (int wx = 0; wx < K; wx++)
                        chki("s2_second_row0", int'(win2[wx*8 +: 8]), 3 + wx);
            end
            n2++;
        end
        if (fd1) nfd++;
    end

    // Window-ready driver; on arming it stalls the first window for 10 cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_arm && vld1) begin
                bp_arm = 0;
                wrdy = 0;
                chki("first_at_pixel", nacc, 117);
                chki("first_if_x", int'(ix1), 0);
                chki("first_if_y", int'(iy1), 0);
                for (int wx = 0; wx < K; wx++) begin
                    chki("first_row0", int'(win1[wx*8 +: 8]), 1 + wx);
                    chki("first_row4", int'(win1[(4*K + wx)*8 +: 8]), 113 + wx);
                    chki("first_ch2_row0", int'(win1[(2*K*K + wx)*8 +: 8]), 129 + wx);
                end
                snap = win1;
                sx = ix1;
                sy = iy1;
                repeat (10) begin
                    @(negedge clk);
                    chki("bp_in_ready", int'(rdy1), 0);
                    chk("bp_window_hold", win1, snap);
                    chki("bp_if_hold", int'({ix1, iy1}), int'({sx, sy}));
                end
                @(posedge clk);
                #1;
                wrdy = 1;
            end else begin
                wrdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        idle(3);
        chk_rst("por");
        rst = 0;
        idle(2);
        bp_arm = 1;
        chk_second = 1;
        frame(0, IX * IY);
        idle(5);
        counts("full_rate", 576, 144, 1);
        chki("bp_seen", int'(bp_arm), 0);
        chk_second = 0;
        n1 = 0;
        n2 = 0;
        nfd = 0;
        gaps = 1;
        rnd = 1;
        f2chk = 1;
        frame(0, IX * IY);
        frame(100, IX * IY);
        gaps = 0;
        rnd = 0;
        idle(10);
        counts("random_two_frames", 1152, 288, 2);
        f2chk = 0;
        frame(50, 300);
        idle(3);
        #2;
        rst = 1;
        #1;
        chk_rst("mid_reset");
        q1.delete();
        q2.delete();
        @(posedge clk);
        #1;
        rst = 0;
        idle(1);
        fresh(30, "after_reset");
        frame(70, 300);
        idle(3);
        clr = 1;
        vin = 1;
        pix = 24'hABCDEF;
        idle(1);
        clr = 0;
        vin = 0;
        chk_rst("clear");
        q1.delete();
        q2.delete();
        fresh(90, "after_clear");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_buffer_mc.md
# line_buffer_mc

Multi-channel, strided sliding-window generator for the CNN front end. It accepts a raster-order feature-map stream with CH parallel channels per beat and stores KY-1 lines per channel. It emits one KX×KY×CH window per qualifying position under a valid/ready handshake with backpressure. It replaces the single-channel, stride-1, no-backpressure line buffer ahead of the convolution cores.

## Interface
- I_F_BW, 8: bits per pixel per channel
- IX, 28: input width (pixels)
- IY, 28: input height (lines)
- KX, 5: window width
- KY, 5: window height
- CH, 1: channels per input beat
- STRIDE, 1: window step in x and y (≥1)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- i_clear  in  1  synchronous soft clear of counters and output register (frame abort)
- i_in_valid  in  1  input beat valid
- o_in_ready  out  1  input beat accepted when i_in_valid && o_in_ready
- i_in_pixel  in  CH*I_F_BW  channel c at bits [c*I_F_BW +: I_F_BW]
- o_window_valid  out  1  window valid
- i_window_ready  in  1  downstream accepts window
- o_window  out  CH*KY*KX*I_F_BW  element (c,wy,wx) at bits [((c*KY+wy)*KX+wx)*I_F_BW +: I_F_BW]; wy=0 top (oldest) row, wx=0 leftmost column
- o_if_x  out  $clog2(IX)  input column of the window's top-left pixel
- o_if_y  out  $clog2(IY)  input row of the window's top-left pixel
- o_frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

## Operation
- Input counters x (0..IX-1) and y (0..IY-1) advance on each accepted beat, raster order. At (IX-1, IY-1) both wrap to 0 and o_frame_done pulses.
- Each channel has KY-1 line memories of IX entries, chained. An accepted beat at column x reads the column-x history from all lines, writes the new pixel into line 0, and shifts each older line down by one.
- The window register is a KX-deep shift of KY-tall columns per channel. The new column enters at wx=KX-1 and wy=KY-1 holds the current pixel.
- A beat at (x,y) qualifies when all of the following hold:
  - x ≥ KX-1 and y ≥ KY-1;
  - (x-(KX-1)) mod STRIDE == 0;
  - (y-(KY-1)) mod STRIDE == 0.
- For a qualifying beat: o_if_x = x-(KX-1) and o_if_y = y-(KY-1).
- Windows per frame = ((IX-KX)/STRIDE+1)·((IY-KY)/STRIDE+1), using integer division.
- Stale rows from the previous frame never appear, because qualification requires y ≥ KY-1 in the current frame. Line memories are not cleared at frame wrap.
- Modulo tracking uses per-axis phase counters (0..STRIDE-1) and no dividers. The phase counters reset to 0 when x or y reaches KX-1 or KY-1 respectively.
- STRIDE=1 must reduce to plain every-position operation.

## Timing
- o_in_ready = !o_window_valid || i_window_ready (combinational; no skid buffer).
- Latency: the window for a qualifying beat accepted at edge N is valid from edge N+1.
- The window shift register advances only on accepted beats. Idle cycles (i_in_valid=0) change no state.
- While o_window_valid && !i_window_ready, o_window, o_if_x and o_if_y hold stable and no input is accepted.
- Simultaneous window accept and qualifying input beat: the new window loads and o_window_valid stays 1.
- Simultaneous window accept and non-qualifying input beat: o_window_valid falls to 0.
- Reset values: o_window_valid=0, o_window=0, o_if_x=0, o_if_y=0, o_frame_done=0, counters=0.
  - o_in_ready is 1 during and after reset.
- Reset mid-frame takes effect immediately (asynchronous). The next accepted beat is treated as pixel (0,0). Line memory contents are don't-care.
- i_clear has the same effect as reset, at the next edge. i_clear has priority over a concurrent input beat, which is dropped.
- Line memories use a 1-cycle read. The implementation pipelines read-modify-write at column x so that back-to-back beats at full rate are lossless.

## Structure
- Package lb_pkg holds the following:
  - helper function win_count(IX,KX,STRIDE);
  - localparams for window bit width and window-index arithmetic;
  - typedef for the per-channel pixel.
- Sub-module lb_row_ram: simple dual-port, IX×(CH*I_F_BW) line memory with one write port and one 1-cycle read port. It is instantiated KY-1 times.
- The top module holds the counters, stride phases, handshake logic and window shift register.

## Test plan
- CH=1, STRIDE=1, 28×28, pixels 1..784 (mod 256), i_window_ready=1:
  - first window after pixel 117 is accepted;
  - row0 = 1 2 3 4 5, row4 = 113..117;
  - o_if_x=0, o_if_y=0;
  - 576 windows total, one o_frame_done pulse.
- STRIDE=2, same stream:
  - exactly 144 windows;
  - o_if_x sequence 0,2,…,22 per row, o_if_y steps by 2;
  - second window row0 = 3..7.
- CH=3, channel c = (pixel + 64·c) mod 256: first window channel 2, row0 = 129..133, and all channels are aligned.
- Backpressure: drop i_window_ready for 10 cycles at first valid window:
  - o_in_ready=0 throughout;
  - o_window and o_if_x/o_if_y are unchanged;
  - no pixel is lost; full window count still matches.
- Random i_in_valid gaps (50%) plus random i_window_ready, two back-to-back frames: 576 windows per frame, each matching the golden model, and frame-2 first window row0 = frame-2 pixels 1..5.
- Assert reset (and separately i_clear) at pixel 300:
  - all outputs return to reset values;
  - a fresh frame then produces its first window at its 117th pixel with o_if_x=0, o_if_y=0.
